// File: rtl/univ_shift_reg_if.sv
// Command/data bundle for the universal shift register.
// The master drives the command and control inputs; the slave returns q/s_out/busy/done.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             enable;
    logic             set;
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             ser_in_lo;
    logic             ser_in_hi;
    logic [WIDTH-1:0] q;
    logic             s_out;
    logic             busy;
    logic             done;

    modport master (
        output enable, set, start, mode, amt, d, ser_in_lo, ser_in_hi,
        input  q, s_out, busy, done
    );

    modport slave (
        input  enable, set, start, mode, amt, d, ser_in_lo, ser_in_hi,
        output q, s_out, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/clear/hold in one cycle, shift/rotate/ASR one bit per enabled clock.
// state | meaning
// IDLE  | waiting for start; single-cycle commands complete here
// RUN   | multi-step shift/rotate in progress, cnt_q steps remaining
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input logic               clk_i,
    input logic               reset_i,
    univ_shift_reg_if.slave   bus
);
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ASR   = 3'b101;
    localparam logic [2:0] MODE_LOAD  = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [AMT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] q_q;
    logic             s_out_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] step_q_d;
    logic             step_s_d;

    // One bit-step of the latched operation; serial inputs are sampled fresh every step.
    always_comb begin
        step_q_d = q_q;
        step_s_d = s_out_q;
        case (op_q)
            MODE_SHL: begin
                step_q_d = {q_q[WIDTH-2:0], bus.ser_in_lo};
                step_s_d = q_q[WIDTH-1];
            end
            MODE_SHR: begin
                step_q_d = {bus.ser_in_hi, q_q[WIDTH-1:1]};
                step_s_d = q_q[0];
            end
            MODE_ROL: begin
                step_q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                step_s_d = q_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_q_d = {q_q[0], q_q[WIDTH-1:1]};
                step_s_d = q_q[0];
            end
            MODE_ASR: begin
                step_q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                step_s_d = q_q[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MODE_HOLD;
            q_q     <= '0;
            s_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.set) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '1;
            s_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!bus.enable) begin
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.mode)
                            MODE_HOLD:  done_q <= 1'b1;
                            MODE_LOAD: begin
                                q_q    <= bus.d;
                                done_q <= 1'b1;
                            end
                            MODE_CLEAR: begin
                                q_q    <= '0;
                                done_q <= 1'b1;
                            end
                            default: begin
                                if (bus.amt == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    op_q    <= bus.mode;
                                    cnt_q   <= bus.amt;
                                    busy_q  <= 1'b1;
                                    state_q <= RUN;
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    q_q     <= step_q_d;
                    s_out_q <= step_s_d;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == AMT_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.q     = q_q;
    assign bus.s_out = s_out_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: commands push their predicted final state,
// a negedge monitor pops and compares on every done pulse.
module tb_univ_shift_reg;
    localparam int W = 8;
    localparam int A = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(W), .AMT_W(A)) bus ();
    univ_shift_reg #(.WIDTH(W), .AMT_W(A)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));

    typedef struct {
        logic [W-1:0] q;
        logic         s;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] m_q;
    logic         m_s;

    // Whole-command reference: multi-bit shifts/rotates as plain arithmetic on a wide word.
    function automatic void model(input logic [2:0] mode, input int n, input logic [W-1:0] d,
                                  input logic lo, input logic hi);
        logic [63:0] x, ext, fillm, mask;
        logic        fill;
        int          r;
        mask = (64'd1 << W) - 64'd1;
        x    = {{(64-W){1'b0}}, m_q};
        case (mode)
            3'd0: ;
            3'd6: m_q = d;
            3'd7: m_q = '0;
            default: if (n > 0) begin
                case (mode)
                    3'd1: begin
                        fillm = lo ? ((64'd1 << n) - 64'd1) : 64'd0;
                        ext   = (x << n) | fillm;
                        m_s   = ext[W];
                        m_q   = ext[W-1:0];
                    end
                    3'd3: begin
                        r   = n % W;
                        m_s = m_q[((W - 1 - (n - 1)) % W + W) % W];
                        ext = ((x << r) | (x >> (W - r))) & mask;
                        m_q = ext[W-1:0];
                    end
                    3'd4: begin
                        r   = n % W;
                        m_s = m_q[(n - 1) % W];
                        ext = ((x >> r) | (x << (W - r))) & mask;
                        m_q = ext[W-1:0];
                    end
                    default: begin
                        fill  = (mode == 3'd5) ? m_q[W-1] : hi;
                        fillm = fill ? (((64'd1 << n) - 64'd1) << W) : 64'd0;
                        ext   = x | fillm;
                        m_s   = ext[n-1];
                        ext   = ext >> n;
                        m_q   = ext[W-1:0];
                    end
                endcase
            end
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && bus.done === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got done=1 q=%h, required no done", bus.q);
            end else begin
                e = exp_q.pop_front();
                if (bus.q !== e.q || bus.s_out !== e.s || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL cmd_result: got q=%h s_out=%b busy=%b, required q=%h s_out=%b busy=0",
                             bus.q, bus.s_out, bus.busy, e.q, e.s);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic issue(input logic [2:0] mode, input int n, input logic [W-1:0] d,
                         input logic lo, input logic hi);
        exp_t e;
        bus.mode      = mode;
        bus.amt       = A'(n);
        bus.d         = d;
        bus.ser_in_lo = lo;
        bus.ser_in_hi = hi;
        bus.enable    = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        model(mode, n, d, lo, hi);
        e.q = m_q;
        e.s = m_s;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int budget, input bit rand_en, output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < budget) begin
            if (rand_en) bus.enable = ($urandom_range(0, 3) != 0);
            tick();
            cycles++;
        end
        bus.enable = 1'b1;
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
        end
    endtask

    initial begin
        int cyc;
        int edges;
        logic [2:0] md;
        reset         = 1'b1;
        bus.set       = 1'b0;
        bus.enable    = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = '0;
        bus.amt       = '0;
        bus.d         = '0;
        bus.ser_in_lo = 1'b0;
        bus.ser_in_hi = 1'b0;
        m_q = '0;
        m_s = 1'b0;
        tick();
        tick();
        chk("reset_q", 32'(bus.q), 32'h00);
        chk("reset_flags", {29'd0, bus.s_out, bus.busy, bus.done}, 32'd0);
        reset = 1'b0;

        // SHL by 3 from 0xA5 with ser_in_lo=1, checked edge by edge
        issue(3'd6, 0, 8'hA5, 1'b0, 1'b0);
        wait_done(4, 1'b0, cyc);
        issue(3'd1, 3, 8'h00, 1'b1, 1'b0);
        chk("shl_busy_k", 32'(bus.busy), 32'd1);
        chk("shl_q_k", 32'(bus.q), 32'hA5);
        tick();
        chk("shl_q_k1", 32'(bus.q), 32'h4B);
        chk("shl_busy_k1", 32'(bus.busy), 32'd1);
        tick();
        chk("shl_q_k2", 32'(bus.q), 32'h97);
        chk("shl_busy_k2", 32'(bus.busy), 32'd1);
        tick();
        chk("shl_q_k3", 32'(bus.q), 32'h2F);
        chk("shl_s_out", 32'(bus.s_out), 32'd1);
        chk("shl_end", {30'd0, bus.busy, bus.done}, 32'd1);
        tick();
        chk("shl_done_once", 32'(bus.done), 32'd0);

        // ROR by full width restores the value
        issue(3'd6, 0, 8'h81, 1'b0, 1'b0);
        wait_done(4, 1'b0, cyc);
        issue(3'd4, 8, 8'h00, 1'b0, 1'b0);
        wait_done(20, 1'b0, cyc);
        chk("ror8_cycles", 32'(cyc), 32'd8);
        chk("ror8_q", 32'(bus.q), 32'h81);

        issue(3'd6, 0, 8'h80, 1'b0, 1'b0);
        wait_done(4, 1'b0, cyc);
        issue(3'd5, 2, 8'h00, 1'b1, 1'b1);
        wait_done(10, 1'b0, cyc);
        chk("asr2_q", 32'(bus.q), 32'hE0);
        chk("asr2_s_out", 32'(bus.s_out), 32'd0);

        // SHR by 5 with a 3-cycle freeze and a start pulse while busy
        issue(3'd6, 0, 8'h3C, 1'b0, 1'b0);
        wait_done(4, 1'b0, cyc);
        issue(3'd2, 5, 8'h00, 1'b0, 1'b1);
        tick();
        tick();
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_busy", 32'(bus.busy), 32'd1);
        end
        bus.enable = 1'b1;
        bus.mode   = 3'd6;
        bus.d      = 8'h00;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(20, 1'b0, cyc);
        edges = 6 + cyc;
        chk("shr5_edges", 32'(edges), 32'd8);
        for (int i = 0; i < 4; i++) tick();

        // set lands on the 2nd step and aborts the command
        issue(3'd6, 0, 8'h5A, 1'b0, 1'b0);
        wait_done(4, 1'b0, cyc);
        issue(3'd1, 6, 8'h00, 1'b0, 1'b0);
        tick();
        bus.set = 1'b1;
        tick();
        bus.set = 1'b0;
        void'(exp_q.pop_back());
        m_q = '1;
        m_s = 1'b0;
        chk("set_q", 32'(bus.q), 32'hFF);
        chk("set_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        issue(3'd6, 0, 8'h12, 1'b0, 1'b0);
        wait_done(4, 1'b0, cyc);
        chk("after_set_load", 32'(bus.q), 32'h12);

        // amt=0 shift and HOLD finish immediately
        issue(3'd1, 0, 8'h00, 1'b1, 1'b1);
        chk("amt0_flags", {30'd0, bus.busy, bus.done}, 32'd1);
        chk("amt0_q", 32'(bus.q), 32'h12);
        wait_done(4, 1'b0, cyc);
        issue(3'd0, 7, 8'hFF, 1'b1, 1'b1);
        chk("hold_flags", {30'd0, bus.busy, bus.done}, 32'd1);
        wait_done(4, 1'b0, cyc);

        for (int i = 0; i < 60; i++) begin
            md = 3'($urandom_range(0, 7));
            issue(md, int'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), 1'($urandom));
            wait_done(200, 1'b1, cyc);
        end

        // reset in the middle of a command, then reset with set also high
        issue(3'd3, 10, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        bus.set = 1'b1;
        tick();
        chk("reset2_q", 32'(bus.q), 32'h00);
        chk("reset2_flags", {29'd0, bus.s_out, bus.busy, bus.done}, 32'd0);
        bus.set = 1'b0;
        reset   = 1'b0;
        m_q = '0;
        m_s = 1'b0;
        tick();
        chk("post_reset_done", 32'(bus.done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
